rsa_job_arbiter: RTL and testbench

Controller that shares one `rsa_unit` modular-exponentiation datapath between two requesters. It accepts jobs (P, E, M, Const) on per-requester valid/ready channels and arbitrates round-robin. For each granted job it resets and runs the unit, waits for `eoc` (bounded by a timeout), and returns the result C on a shared response channel tagged with the requester id. It sits directly above `rsa_unit` and owns all of the unit's control and operand inputs.

---
 rtl/rsa_job_arbiter.sv | 120 ++++++++++++
 tb/tb_rsa_job_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_arbiter.sv
// Two-requester round-robin front end for a single rsa_unit: accepts a job,
// clears and runs the unit, waits for eoc or a timeout, then returns the result.
module rsa_job_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_p,
    input  logic [2*WIDTH-1:0] req_e,
    input  logic [2*WIDTH-1:0] req_m,
    input  logic [2*WIDTH-1:0] req_const,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [WIDTH-1:0]   resp_data,
    output logic               resp_err,
    output logic               busy,
    output logic               rsa_en,
    output logic               rsa_rstb,
    output logic [WIDTH-1:0]   rsa_p,
    output logic [WIDTH-1:0]   rsa_e,
    output logic [WIDTH-1:0]   rsa_m,
    output logic [WIDTH-1:0]   rsa_const,
    input  logic [WIDTH-1:0]   rsa_c,
    input  logic               rsa_eoc
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             owner;
    logic             grant;
    logic             accept;
    logic             run_end;

    assign accept  = |(req_valid & req_ready);
    assign run_end = rsa_eoc || (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            rsa_en     <= 1'b0;
            rsa_rstb   <= 1'b0;
            rsa_p      <= '0;
            rsa_e      <= '0;
            rsa_m      <= '0;
            rsa_const  <= '0;
        end else begin
            state <= state_next;
            // Control outputs are registered copies of the upcoming state
            busy       <= (state_next != IDLE);
            rsa_en     <= (state_next == RUN);
            rsa_rstb   <= (state_next != CLEAR);
            resp_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant;
                        last_grant <= grant;
                        rsa_p      <= grant ? req_p[WIDTH +: WIDTH]     : req_p[0 +: WIDTH];
                        rsa_e      <= grant ? req_e[WIDTH +: WIDTH]     : req_e[0 +: WIDTH];
                        rsa_m      <= grant ? req_m[WIDTH +: WIDTH]     : req_m[0 +: WIDTH];
                        rsa_const  <= grant ? req_const[WIDTH +: WIDTH] : req_const[0 +: WIDTH];
                    end
                end
                CLEAR: cnt <= '0;
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // eoc has priority over a timeout landing on the same cycle
                    if (rsa_eoc) begin
                        resp_data <= rsa_c;
                        resp_err  <= 1'b0;
                        resp_id   <= owner;
                    end else if (cnt == CNT_LAST) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        resp_id   <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CLEAR;
            CLEAR:   state_next = RUN;
            RUN:     if (run_end) state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        req_ready = 2'b00;
        if (state == IDLE && !rst && req_valid != 2'b00)
            req_ready = grant ? 2'b10 : 2'b01;
    end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: a stub unit with programmable eoc latency and a
// grant/result reference model built from the arbitration and timeout rules.
module tb_rsa_job_arbiter;

    localparam int W  = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_p, req_e, req_m, req_const;
    logic           resp_valid, resp_ready, resp_id, resp_err, busy;
    logic [W-1:0]   resp_data;
    logic           rsa_en, rsa_rstb, rsa_eoc;
    logic [W-1:0]   rsa_p, rsa_e, rsa_m, rsa_const, rsa_c;

    int       stub_lat = 0;
    int       sc = 0;
    logic     eoc_force = 1'b0;
    logic [7:0] op_p[2], op_e[2], op_m[2], op_c[2];
    logic     model_last;
    int       ncmp = 0;
    int       nfail = 0;

    rsa_job_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_p(req_p), .req_e(req_e), .req_m(req_m), .req_const(req_const),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
        .rsa_en(rsa_en), .rsa_rstb(rsa_rstb),
        .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
        .rsa_c(rsa_c), .rsa_eoc(rsa_eoc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] modexp(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m);
        longint r, x;
        if (m == 8'd0) return 8'd0;
        r = 1 % longint'(m);
        x = longint'(b) % longint'(m);
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = (r * x) % longint'(m);
            x = (x * x) % longint'(m);
        end
        return 8'(r);
    endfunction

    // Stub unit: counts enabled cycles since its reset and raises eoc after stub_lat of them
    always @(posedge clk) begin
        if (!rsa_rstb) sc <= 0;
        else if (rsa_en) sc <= sc + 1;
    end
    assign rsa_eoc = eoc_force | (rsa_en & rsa_rstb & (stub_lat != 0) & (sc == stub_lat - 1));
    assign rsa_c   = modexp(rsa_p, rsa_e, rsa_m);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 2; i++) begin
            op_p[i] = 8'($urandom);
            op_e[i] = 8'($urandom);
            op_m[i] = 8'($urandom_range(2, 255));
            op_c[i] = 8'($urandom);
        end
    endtask

    task automatic drive_ops();
        req_p     = {op_p[1], op_p[0]};
        req_e     = {op_e[1], op_e[0]};
        req_m     = {op_m[1], op_m[0]};
        req_const = {op_c[1], op_c[0]};
    endtask

    // Called at a negedge with the DUT idle; returns granted id and result.
    task automatic do_job(input logic [1:0] v, input int lat, input int hold,
                          output logic g, output logic [7:0] dat, output logic err);
        int   n;
        int   exp_n;
        logic [1:0] nxt_g;
        stub_lat = lat;
        drive_ops();
        req_valid = v;
        #1;
        g = (v == 2'b11) ? ~model_last : v[1];
        chk("req_ready_idle", req_ready, g ? 2'b10 : 2'b01);
        @(negedge clk);
        model_last = g;
        req_valid  = 2'b00;
        req_p = 16'($urandom); req_e = 16'($urandom); req_m = 16'($urandom); req_const = 16'($urandom);
        chk("clear_busy", busy, 1'b1);
        chk("clear_rstb", rsa_rstb, 1'b0);
        chk("clear_en", rsa_en, 1'b0);
        chk("op_p", rsa_p, op_p[g]);
        chk("op_e", rsa_e, op_e[g]);
        chk("op_m", rsa_m, op_m[g]);
        chk("op_const", rsa_const, op_c[g]);
        @(negedge clk);
        chk("run_en", {rsa_en, rsa_rstb}, 2'b11);
        n = 0;
        while (resp_valid !== 1'b1 && n < TO + 8) begin
            @(negedge clk);
            n++;
        end
        err   = (lat == 0 || lat > TO);
        exp_n = err ? TO : lat;
        dat   = err ? 8'd0 : modexp(op_p[g], op_e[g], op_m[g]);
        chk("run_cycles", n, exp_n);
        chk("resp_id", resp_id, g);
        chk("resp_err", resp_err, err);
        chk("resp_data", resp_data, dat);
        chk("done_ctrl", {rsa_en, rsa_rstb, busy}, 3'b011);
        req_valid = 2'b11;
        eoc_force = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_ready", req_ready, 2'b00);
            chk("hold_resp", {resp_valid, resp_id, resp_err, resp_data}, {1'b1, g, err, dat});
        end
        eoc_force  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_hs", {resp_valid, busy}, 2'b00);
        nxt_g = ~g ? 2'b10 : 2'b01;
        chk("post_hs_ready", req_ready, nxt_g);
        req_valid = 2'b00;
    endtask

    initial begin
        logic       g;
        logic [7:0] dat;
        logic       err;
        logic       seen;

        rst = 1'b1; req_valid = 2'b11; resp_ready = 1'b0; model_last = 1'b1;
        rand_ops(); drive_ops();
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_resp", {resp_valid, resp_id, resp_err, resp_data}, 11'd0);
        chk("rst_ctrl", {busy, rsa_en, rsa_rstb}, 3'b000);
        chk("rst_ops", {rsa_p, rsa_e, rsa_m, rsa_const}, 32'd0);
        rst = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        chk("rstb_rise", rsa_rstb, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // Both valid from reset: strict alternation starting with requester 0
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            do_job(2'b11, $urandom_range(1, 10), 0, g, dat, err);
            chk("alt_order", g, k[0]);
        end

        op_p[0] = 8'd7; op_e[0] = 8'd3; op_m[0] = 8'd33; op_c[0] = 8'd1;
        op_p[1] = 8'd9; op_e[1] = 8'd5; op_m[1] = 8'd77; op_c[1] = 8'd2;
        do_job(2'b01, 6, 0, g, dat, err);
        chk("directed_c", dat, 8'd13);

        rand_ops();
        do_job(2'b10, 1, 0, g, dat, err);
        rand_ops();
        do_job(2'b01, 0, 0, g, dat, err);
        chk("timeout_err", err, 1'b1);
        rand_ops();
        do_job(2'b10, TO, 0, g, dat, err);
        chk("eoc_wins", err, 1'b0);
        rand_ops();
        do_job(2'b01, TO + 1, 0, g, dat, err);
        rand_ops();
        do_job(2'b11, 4, 10, g, dat, err);

        // Reset in the middle of RUN drops the job
        rand_ops(); drive_ops();
        stub_lat = 0;
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (5) @(negedge clk);
        rst = 1'b1; req_valid = 2'b11;
        @(negedge clk);
        chk("midrst_ctrl", {busy, rsa_en, rsa_rstb, resp_valid}, 4'b0000);
        chk("midrst_ready", req_ready, 2'b00);
        chk("midrst_ops", rsa_p, 8'd0);
        rst = 1'b0; req_valid = 2'b00; model_last = 1'b1; stub_lat = 3;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_resp", seen, 1'b0);
        rand_ops();
        do_job(2'b11, 5, 0, g, dat, err);
        chk("tie_after_rst", g, 1'b0);

        for (int k = 0; k < 12; k++) begin
            rand_ops();
            do_job(2'($urandom_range(1, 3)), $urandom_range(0, 18), $urandom_range(0, 3), g, dat, err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
